// File: rtl/div_rill_pkg.sv
// Shared definitions for the sequential restoring divider.
// Holds the default operand width, the controller states and the counter sizing rule.
package div_rill_pkg;

    localparam int DEF_WIDTH = 32;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // One extra bit so the counter can represent WIDTH itself without wrapping.
    function automatic int cnt_width(input int w);
        return $clog2(w) + 1;
    endfunction

    localparam int DEF_CNT_W = cnt_width(DEF_WIDTH);

endpackage

// File: rtl/div_rill_seq_if.sv
// Start/done handshake and operand/result bus of the divider.
// master drives the request side, slave is the divider itself.
interface div_rill_seq_if
    import div_rill_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] yshang;
    logic [WIDTH-1:0] yyushu;

    modport master (
        output start, a, b,
        input  busy, done, yshang, yyushu
    );

    modport slave (
        input  start, a, b,
        output busy, done, yshang, yyushu
    );

endinterface

// File: rtl/div_rill_step.sv
// One radix-2 restoring iteration: shift in a dividend bit, trial-subtract the divisor.
// Purely combinational; the top level registers its results every RUN cycle.
module div_rill_step
    import div_rill_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] rem,
    input  logic             din,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_nxt,
    output logic             qbit
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    // rem < divisor always holds, so the top bit of the WIDTH+1 difference is exactly the borrow.
    assign shifted = {rem, din};
    assign trial   = shifted - {1'b0, divisor};
    assign qbit    = ~trial[WIDTH];
    assign rem_nxt = qbit ? trial[WIDTH-1:0] : {rem[WIDTH-2:0], din};

endmodule

// File: rtl/div_rill_seq.sv
// Sequential unsigned divider: one quotient bit per clock, WIDTH cycles per division.
// Results are registered and held until the next completion pulses done.
module div_rill_seq
    import div_rill_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic         clk,
    input  logic         rst_n,
    div_rill_seq_if.slave bus
);

    localparam int CNT_W = cnt_width(WIDTH);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] div_q;
    logic [WIDTH-1:0] rem_nxt;
    logic             qbit;
    logic             last_iter;
    logic             busy;
    logic             done_q;
    logic [WIDTH-1:0] yshang_q;
    logic [WIDTH-1:0] yyushu_q;

    div_rill_step #(.WIDTH(WIDTH)) u_step (
        .rem     (rem_q),
        .din     (quo_q[WIDTH-1]),
        .divisor (div_q),
        .rem_nxt (rem_nxt),
        .qbit    (qbit)
    );

    assign last_iter = (cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        case (state)
            IDLE: if (bus.start) state_nxt = RUN;
            RUN: begin
                busy = 1'b1;
                if (last_iter) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // quo_q doubles as the dividend shifter: dividend bits leave the top as quotient bits enter the bottom.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt      <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            div_q    <= '0;
            done_q   <= 1'b0;
            yshang_q <= '0;
            yyushu_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        quo_q <= bus.a;
                        div_q <= bus.b;
                        rem_q <= '0;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    rem_q <= rem_nxt;
                    quo_q <= {quo_q[WIDTH-2:0], qbit};
                    cnt   <= cnt + CNT_W'(1);
                    if (last_iter) begin
                        yshang_q <= {quo_q[WIDTH-2:0], qbit};
                        yyushu_q <= rem_nxt;
                        done_q   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy   = busy;
    assign bus.done   = done_q;
    assign bus.yshang = yshang_q;
    assign bus.yyushu = yyushu_q;

endmodule

// File: tb/tb_div_rill_seq.sv
// Self-checking bench for div_rill_seq: directed cases, reset abort and randomized operands
// compared against plain division arithmetic.
module tb_div_rill_seq;

    localparam int WIDTH = 32;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    logic [WIDTH-1:0] lastQ;
    logic [WIDTH-1:0] lastR;

    div_rill_seq_if #(.WIDTH(WIDTH)) bus ();

    div_rill_seq #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Launches one division, disturbs the bus while it runs, and checks the result against a / b.
    task automatic applyStimulus(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv, input string tag);
        logic [WIDTH-1:0] expQ;
        logic [WIDTH-1:0] expR;
        logic [63:0]      recon;
        int               lat;
        if (bv == 0) begin
            expQ = '1;
            expR = av;
        end else begin
            expQ = av / bv;
            expR = av % bv;
        end
        bus.a     = av;
        bus.b     = bv;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        checkOutput({tag, "_busy_rise"}, 64'(bus.busy), 64'd1);
        lat = 0;
        for (int i = 1; i <= WIDTH + 4; i++) begin
            bus.start = (i == 5);
            if (i == 10) begin
                bus.a = $urandom;
                bus.b = $urandom;
            end
            @(posedge clk);
            #1;
            if (i == WIDTH / 2) begin
                checkOutput({tag, "_hold_q"}, 64'(bus.yshang), 64'(lastQ));
                checkOutput({tag, "_hold_r"}, 64'(bus.yyushu), 64'(lastR));
            end
            if (bus.done) begin
                lat = i;
                break;
            end
        end
        bus.start = 1'b0;
        checkOutput({tag, "_latency"}, 64'(lat), 64'(WIDTH));
        checkOutput({tag, "_busy_fall"}, 64'(bus.busy), 64'd0);
        checkOutput({tag, "_q"}, 64'(bus.yshang), 64'(expQ));
        checkOutput({tag, "_r"}, 64'(bus.yyushu), 64'(expR));
        if (bv != 0) begin
            recon = 64'(bus.yshang) * 64'(bv) + 64'(bus.yyushu);
            checkOutput({tag, "_invariant"}, recon, 64'(av));
            checkOutput({tag, "_r_lt_b"}, 64'(bus.yyushu < bv), 64'd1);
        end
        @(posedge clk);
        #1;
        checkOutput({tag, "_done_pulse"}, 64'(bus.done), 64'd0);
        lastQ = expQ;
        lastR = expR;
    endtask

    task automatic resetAbort();
        int seenDone;
        bus.a     = 32'd987654;
        bus.b     = 32'd321;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        for (int i = 1; i < 10; i++) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        checkOutput("abort_busy", 64'(bus.busy), 64'd0);
        checkOutput("abort_done", 64'(bus.done), 64'd0);
        checkOutput("abort_q", 64'(bus.yshang), 64'd0);
        checkOutput("abort_r", 64'(bus.yyushu), 64'd0);
        seenDone = 0;
        for (int i = 0; i < WIDTH + 8; i++) begin
            @(posedge clk);
            #1;
            if (bus.done) seenDone++;
        end
        checkOutput("abort_no_done", 64'(seenDone), 64'd0);
        lastQ = '0;
        lastR = '0;
    endtask

    initial begin
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;
        total     = 0;
        bad       = 0;
        lastQ     = '0;
        lastR     = '0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        checkOutput("reset_busy", 64'(bus.busy), 64'd0);
        checkOutput("reset_done", 64'(bus.done), 64'd0);
        checkOutput("reset_q", 64'(bus.yshang), 64'd0);
        checkOutput("reset_r", 64'(bus.yyushu), 64'd0);

        applyStimulus(32'd6841, 32'd4532, "t6841");
        applyStimulus(32'd453, 32'd274, "t453");
        applyStimulus(32'd4637, 32'd123, "t4637");
        applyStimulus(32'hFFFF_FFFF, 32'd1, "max_by1");
        applyStimulus(32'd5, 32'd7, "a_lt_b");
        applyStimulus(32'd0, 32'd9, "zero_a");
        applyStimulus(32'd100, 32'd0, "div0");
        resetAbort();
        applyStimulus(32'd1000, 32'd7, "post_reset");

        for (int n = 0; n < 1000; n++) begin
            ra = $urandom;
            case ($urandom_range(0, 3))
                0:       rb = '0;
                1:       rb = WIDTH'($urandom_range(1, 255));
                2:       rb = ra >> $urandom_range(0, 31);
                default: rb = $urandom;
            endcase
            applyStimulus(ra, rb, "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/div_rill_seq.md
# div_rill_seq

Sequential unsigned integer divider for the k-means datapath (cluster-centroid averaging). Accepts a dividend `a` and a divisor `b` and returns quotient `yshang` and remainder `yyushu`. Uses a radix-2 restoring shift/subtract algorithm, one quotient bit per clock, with a start/done handshake.

## Interface
- `WIDTH`, default 32: operand, quotient and remainder width.
- `clk`  input  1  system clock; all state updates on its rising edge.
- `rst_n`  input  1  reset; synchronous, active-low.
- `start`  input  1  request a division; sampled only while idle.
- `a`  input  WIDTH  dividend, unsigned; captured on the accepted `start` edge.
- `b`  input  WIDTH  divisor, unsigned; captured on the accepted `start` edge.
- `busy`  output  1  high while a division is in progress.
- `done`  output  1  one-cycle pulse when new results are valid.
- `yshang`  output  WIDTH  quotient, registered.
- `yyushu`  output  WIDTH  remainder, registered.

## Operation
- States:
  - IDLE: `busy`=0. Goes to RUN on `start`=1. On entry to RUN, latch `a` into the quotient/shift register and `b` into the divisor register, clear the partial remainder, and clear the bit counter.
  - RUN: `busy`=1. Each cycle:
    - shift {remainder, dividend} left by 1;
    - trial = remainder − divisor, computed WIDTH+1 bits wide;
    - if there is no borrow: remainder = trial and the quotient LSB = 1;
    - otherwise: keep the remainder and the quotient LSB = 0.
  - After WIDTH iterations: write the quotient and remainder to `yshang`/`yyushu`, pulse `done`, return to IDLE.
- All arithmetic is unsigned. Results satisfy a = yshang·b + yyushu with yyushu < b, for b ≠ 0.
- Divide by zero (b = 0) follows the algorithm naturally: `yshang` = all ones, `yyushu` = a. No error flag.
- `a` < `b`: `yshang` = 0, `yyushu` = a.
- `start` while busy is ignored. Changes on `a`/`b` after capture have no effect on the running division.
- `yshang`/`yyushu` hold the last result until the next completion; they do not change during RUN.

## Timing
- Reset (rst_n=0 at an edge) puts the block in IDLE with `busy`=0, `done`=0, `yshang`=0, `yyushu`=0, and clears all internal registers.
- Reset mid-operation aborts the division; no `done` pulse follows.
- Latency:
  - `start` is accepted at edge N.
  - Iterations occur at edges N+1 … N+WIDTH.
  - Results and `done`=1 are visible after edge N+WIDTH (32 cycles for the default width).
- `done` is high for exactly one cycle, and `busy` falls on the same edge.
- A new `start` can be accepted at edge N+WIDTH+1. Back-to-back throughput is one division per WIDTH+1 cycles.
- `start` held high continuously launches a new division each time the block returns to IDLE.

## Structure
- Shared package `div_rill_pkg`:
  - default WIDTH constant;
  - state enum {IDLE, RUN};
  - counter width = $clog2(WIDTH)+1.
- One natural sub-module: `div_rill_step`. It is combinational: it takes the current remainder, the incoming dividend bit and the divisor, and returns the next remainder and the quotient bit. The top level instantiates it once and wraps it with the state machine, counter and output registers.

## Test plan
- a=6841, b=4532, start → after 32 cycles: done, yshang=1, yyushu=2309.
- a=453, b=274 → yshang=1, yyushu=179. Then a=4637, b=123 → yshang=37, yyushu=86; also verify `busy` timing between the two.
- Boundaries:
  - a=0xFFFFFFFF, b=1 → yshang=0xFFFFFFFF, yyushu=0.
  - a=5, b=7 → yshang=0, yyushu=5.
  - a=0, b=9 → 0, 0.
- Divide by zero: a=100, b=0 → yshang=0xFFFFFFFF, yyushu=100.
- Robustness:
  - pulse `start` with new operands while busy → ignored, first result unchanged;
  - change `a`/`b` mid-run → result unaffected;
  - assert rst_n=0 at iteration 10 → no `done`, outputs 0, next division correct.
- Randomized: 1000 random a/b including b=0 → check the a = q·b + r invariant (b ≠ 0), exact done latency, and a single-cycle `done` pulse.
